// File: rtl/aer_sample_sequencer.sv
// Sequences one sample's spike events from a host stream into the core's
// four-phase AER input port, holds the sample's polarity/mode pins, and
// returns the goodness the core reports at sample end.
module aer_sample_sequencer #(
  parameter int AER_WIDTH   = 12,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 1023,
  parameter int GOOD_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [AER_WIDTH-1:0]  EVT_DATA,
  input  logic                  EVT_LAST,
  input  logic                  EVT_VALID,
  output logic                  EVT_READY,
  input  logic                  SAMPLE_POS,
  input  logic                  SAMPLE_TRAIN,
  output logic [AER_WIDTH-1:0]  AERIN_ADDR,
  output logic                  AERIN_REQ,
  input  logic                  AERIN_ACK,
  output logic                  IS_POS,
  output logic                  IS_TRAIN,
  input  logic [GOOD_WIDTH-1:0] GOODNESS,
  input  logic                  PROCESS_DONE,
  output logic [GOOD_WIDTH-1:0] RESULT_GOODNESS,
  output logic                  RESULT_VALID,
  input  logic                  RESULT_READY,
  output logic                  BUSY,
  output logic                  TIMEOUT_ERR
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int ENTRY_W = AER_WIDTH + 1;
  localparam logic [PTR_W:0] FULL_COUNT   = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_WAIT_DONE,
    S_RESULT,
    S_ERR
  } state_t;

  state_t state_reg, state_next;

  // Event FIFO: each entry is {last, addr}
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  logic                  closed_reg, busy_reg, done_seen_reg;
  logic                  last_reg;
  logic [AER_WIDTH-1:0]  addr_reg;
  logic                  is_pos_reg, is_train_reg;
  logic [GOOD_WIDTH-1:0] goodness_reg;
  logic [CNT_W-1:0]      phase_cnt_reg;
  logic                  phase_expired;
  logic                  in_err;
  logic                  result_hs;

  assign fifo_full     = (count_reg == FULL_COUNT);
  assign fifo_empty    = (count_reg == '0);
  assign fifo_head     = fifo_mem[rd_ptr_reg];
  assign phase_expired = (phase_cnt_reg == PHASE_LAST);
  assign in_err        = (state_reg == S_ERR);

  // Acceptance uses only registered flags, so a same-cycle pop never lets a push in at full
  assign EVT_READY = !RST && !fifo_full && !closed_reg && !in_err;
  assign push      = EVT_VALID && EVT_READY;
  assign result_hs = RESULT_VALID && RESULT_READY;

  assign AERIN_ADDR      = addr_reg;
  assign IS_POS          = is_pos_reg;
  assign IS_TRAIN        = is_train_reg;
  assign RESULT_GOODNESS = goodness_reg;
  assign BUSY            = busy_reg;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; also decides when the FIFO head is consumed
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (AERIN_ACK)          state_next = S_REL;
        else if (phase_expired) state_next = S_ERR;
      end
      S_REL: begin
        if (!AERIN_ACK) begin
          if (last_reg) begin
            state_next = S_WAIT_DONE;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = S_REQ;
          end else begin
            state_next = S_IDLE;
          end
        end else if (phase_expired) begin
          state_next = S_ERR;
        end
      end
      S_WAIT_DONE: begin
        if (done_seen_reg) state_next = S_RESULT;
      end
      S_RESULT: begin
        if (RESULT_READY) state_next = S_IDLE;
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    AERIN_REQ    = (state_reg == S_REQ);
    RESULT_VALID = (state_reg == S_RESULT);
    TIMEOUT_ERR  = in_err;
  end

  // FIFO storage write (no reset so it maps onto RAM)
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= {EVT_LAST, EVT_DATA};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Popped entry drives the core address; it only moves on a pop
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_reg <= '0;
      last_reg <= 1'b0;
    end else if (pop) begin
      addr_reg <= fifo_head[AER_WIDTH-1:0];
      last_reg <= fifo_head[AER_WIDTH];
    end
  end

  // Handshake phase counter: restarts on every state change, counts while in REQ/REL
  always_ff @(posedge CLK) begin
    if (RST || (state_next != state_reg))
      phase_cnt_reg <= '0;
    else if ((state_reg == S_REQ) || (state_reg == S_REL))
      phase_cnt_reg <= phase_cnt_reg + CNT_W'(1);
  end

  // Sample bookkeeping: polarity latch, busy/closed, done capture; result handshake clears last
  always_ff @(posedge CLK) begin
    if (RST) begin
      is_pos_reg    <= 1'b0;
      is_train_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      closed_reg    <= 1'b0;
      done_seen_reg <= 1'b0;
      goodness_reg  <= '0;
    end else begin
      if (push && !busy_reg) begin
        is_pos_reg   <= SAMPLE_POS;
        is_train_reg <= SAMPLE_TRAIN;
        busy_reg     <= 1'b1;
      end
      if (push && EVT_LAST) closed_reg <= 1'b1;
      // The done pulse may land before the final release completes, so capture in any state
      if (PROCESS_DONE && busy_reg) begin
        done_seen_reg <= 1'b1;
        goodness_reg  <= GOODNESS;
      end
      if (result_hs) begin
        busy_reg      <= 1'b0;
        closed_reg    <= 1'b0;
        done_seen_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aer_sample_sequencer.sv
// Self-checking bench: randomized samples, a behavioural core responder,
// and a result monitor checking against queues filled as stimulus is accepted.
module tb_aer_sample_sequencer;

  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int TMO   = 32;
  localparam int GW    = 32;

  logic          clk = 1'b0;
  logic          RST;
  logic [AW-1:0] EVT_DATA;
  logic          EVT_LAST, EVT_VALID, EVT_READY;
  logic          SAMPLE_POS, SAMPLE_TRAIN;
  logic [AW-1:0] AERIN_ADDR;
  logic          AERIN_REQ, AERIN_ACK;
  logic          IS_POS, IS_TRAIN;
  logic [GW-1:0] GOODNESS;
  logic          PROCESS_DONE;
  logic [GW-1:0] RESULT_GOODNESS;
  logic          RESULT_VALID, RESULT_READY;
  logic          BUSY, TIMEOUT_ERR;

  aer_sample_sequencer #(
    .AER_WIDTH(AW), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO), .GOOD_WIDTH(GW)
  ) dut (
    .CLK(clk), .RST(RST),
    .EVT_DATA(EVT_DATA), .EVT_LAST(EVT_LAST), .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
    .SAMPLE_POS(SAMPLE_POS), .SAMPLE_TRAIN(SAMPLE_TRAIN),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .IS_POS(IS_POS), .IS_TRAIN(IS_TRAIN),
    .GOODNESS(GOODNESS), .PROCESS_DONE(PROCESS_DONE),
    .RESULT_GOODNESS(RESULT_GOODNESS), .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: accepted events in order, per-sample polarity, expected goodness
  logic [AW:0]   exp_evt[$];
  logic [1:0]    exp_pol[$];
  logic [GW-1:0] exp_good[$];
  bit            in_sample = 1'b0;
  int            expected_results = 0;
  int            results_done = 0;
  int            hs_cycle = 0;

  // Responder / consumer controls
  bit          ack_stall = 1'b0;
  bit          ack_never = 1'b0;
  bit          early_done = 1'b0;
  bit          fixed_good_en = 1'b0;
  bit          stray_pulse = 1'b0;
  bit          ready_hold = 1'b0;
  int          ack_min = 0;
  int          ack_max = 3;
  logic [GW-1:0] fixed_good = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void record(logic [AW-1:0] a, bit l, bit p, bit t);
    exp_evt.push_back({l, a});
    if (!in_sample) begin
      exp_pol.push_back({p, t});
      in_sample = 1'b1;
    end
    if (l) begin
      in_sample = 1'b0;
      expected_results++;
    end
  endfunction

  // Offer one event at the current negedge and wait (bounded) until it is taken
  task automatic send(input logic [AW-1:0] a, input bit l, input bit p, input bit t);
    int n;
    EVT_DATA = a; EVT_LAST = l; SAMPLE_POS = p; SAMPLE_TRAIN = t; EVT_VALID = 1'b1;
    n = 0;
    while (!EVT_READY && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!EVT_READY) begin
      n_checks++; n_errors++;
      $display("FAIL send_accept actual=not accepted required=accepted addr=%0d", a);
    end else begin
      record(a, l, p, t);
    end
    @(negedge clk);
    EVT_VALID = 1'b0;
  endtask

  task automatic wait_results();
    int n;
    n = 0;
    while (results_done != expected_results && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("results_complete", 64'(results_done), 64'(expected_results));
  endtask

  task automatic check_reset_state();
    check("rst_req",      64'(AERIN_REQ), 0);
    check("rst_addr",     64'(AERIN_ADDR), 0);
    check("rst_is_pos",   64'(IS_POS), 0);
    check("rst_is_train", 64'(IS_TRAIN), 0);
    check("rst_rvalid",   64'(RESULT_VALID), 0);
    check("rst_rgood",    64'(RESULT_GOODNESS), 0);
    check("rst_busy",     64'(BUSY), 0);
    check("rst_tmo",      64'(TIMEOUT_ERR), 0);
    check("rst_evt_ready", 64'(EVT_READY), 1);
  endtask

  // Core model: checks every request against the accepted-event order, then acks it
  logic [AW:0]   r_evt;
  logic [AW-1:0] r_addr;
  logic [GW-1:0] r_good;
  bit            r_stable;
  int            r_d;
  initial begin : core_model
    AERIN_ACK = 1'b0; PROCESS_DONE = 1'b0; GOODNESS = '0;
    forever begin
      @(negedge clk);
      GOODNESS = $urandom;
      if (RST) begin
        AERIN_ACK = 1'b0;
        PROCESS_DONE = 1'b0;
        continue;
      end
      if (stray_pulse && !AERIN_REQ) begin
        PROCESS_DONE = 1'b1;
        GOODNESS = 32'hDEAD_BEEF;
        stray_pulse = 1'b0;
        @(negedge clk);
        PROCESS_DONE = 1'b0;
        continue;
      end
      if (!AERIN_REQ) continue;
      r_addr = AERIN_ADDR;
      if (exp_evt.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL req_extra actual=addr %0d required=no request", r_addr);
        r_evt = '0;
      end else begin
        r_evt = exp_evt.pop_front();
        check("req_addr", 64'(r_addr), 64'(r_evt[AW-1:0]));
      end
      if (exp_pol.size() > 0) begin
        check("is_pos", 64'(IS_POS), 64'(exp_pol[0][1]));
        check("is_train", 64'(IS_TRAIN), 64'(exp_pol[0][0]));
      end
      $display("req addr=%0d last=%0b pos=%0b train=%0b", r_addr, r_evt[AW], IS_POS, IS_TRAIN);
      r_stable = 1'b1;
      if (ack_never) begin
        r_d = 0;
        while (AERIN_REQ && r_d < 300) begin
          @(negedge clk);
          if (AERIN_REQ && AERIN_ADDR != r_addr) r_stable = 1'b0;
          r_d++;
        end
        check("tmo_addr_stable", 64'(r_stable), 1);
        continue;
      end
      while (ack_stall) begin
        @(negedge clk);
        if (AERIN_ADDR != r_addr || !AERIN_REQ) r_stable = 1'b0;
      end
      r_d = $urandom_range(ack_max, ack_min);
      repeat (r_d) begin
        @(negedge clk);
        GOODNESS = $urandom;
        if (AERIN_ADDR != r_addr || !AERIN_REQ) r_stable = 1'b0;
      end
      AERIN_ACK = 1'b1;
      @(negedge clk);
      check("req_drop_after_ack", 64'(AERIN_REQ), 0);
      check("addr_stable", 64'(r_stable), 1);
      if (r_evt[AW] && early_done) begin
        r_good = $urandom;
        PROCESS_DONE = 1'b1;
        GOODNESS = r_good;
        exp_good.push_back(r_good);
        @(negedge clk);
        PROCESS_DONE = 1'b0;
        GOODNESS = $urandom;
        AERIN_ACK = 1'b0;
        @(negedge clk);
        check("early_valid_k1", 64'(RESULT_VALID), 0);
        @(negedge clk);
        check("early_valid_k2", 64'(RESULT_VALID), 1);
      end else begin
        r_d = $urandom_range(2, 0);
        repeat (r_d) @(negedge clk);
        AERIN_ACK = 1'b0;
        if (r_evt[AW]) begin
          r_d = $urandom_range(4, 1);
          repeat (r_d) begin
            @(negedge clk);
            GOODNESS = $urandom;
          end
          r_good = fixed_good_en ? fixed_good : GW'($urandom);
          PROCESS_DONE = 1'b1;
          GOODNESS = r_good;
          exp_good.push_back(r_good);
          @(negedge clk);
          PROCESS_DONE = 1'b0;
          GOODNESS = $urandom;
        end
      end
    end
  end

  // Result monitor: takes results with random back-pressure and compares with the model
  bit            c_was_valid = 1'b0;
  bit            c_held_ok = 1'b1;
  logic [1:0]    c_pol;
  logic [GW-1:0] c_exp;
  initial begin : result_monitor
    RESULT_READY = 1'b0;
    forever begin
      @(negedge clk);
      if (RST) begin
        RESULT_READY = 1'b0;
        c_was_valid = 1'b0;
        c_held_ok = 1'b1;
        continue;
      end
      if (c_was_valid && !RESULT_VALID) c_held_ok = 1'b0;
      c_was_valid = RESULT_VALID;
      if (RESULT_VALID && !ready_hold && $urandom_range(2, 0) == 0) begin
        RESULT_READY = 1'b1;
        hs_cycle = cyc + 1;
        if (exp_good.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL result_extra actual=0x%0h required=no result", RESULT_GOODNESS);
        end else begin
          c_exp = exp_good.pop_front();
          check("result_goodness", 64'(RESULT_GOODNESS), 64'(c_exp));
        end
        check("valid_held", 64'(c_held_ok), 1);
        if (exp_pol.size() > 0) c_pol = exp_pol.pop_front();
        $display("result goodness=0x%08h", RESULT_GOODNESS);
        @(negedge clk);
        RESULT_READY = 1'b0;
        check("busy_after_result", 64'(BUSY), 0);
        check("ready_after_result", 64'(EVT_READY), 1);
        check("valid_after_result", 64'(RESULT_VALID), 0);
        c_was_valid = 1'b0;
        c_held_ok = 1'b1;
        results_done++;
      end
    end
  end

  // Stimulus sequence
  logic [AW-1:0] bp_addr [20];
  initial begin : stimulus
    int sent, blocked, n, len, gap, hi;
    bit p, t, refused;
    RST = 1'b1; EVT_DATA = '0; EVT_LAST = 1'b0; EVT_VALID = 1'b0;
    SAMPLE_POS = 1'b0; SAMPLE_TRAIN = 1'b0;
    repeat (3) @(negedge clk);
    check("ready_in_reset", 64'(EVT_READY), 0);
    RST = 1'b0;
    @(negedge clk);
    check_reset_state();

    // Fixed three-event sample, ACK three cycles after REQ, known goodness
    ack_min = 3; ack_max = 3; fixed_good_en = 1'b1; fixed_good = 32'h0000_1234;
    send(12'd5, 1'b0, 1'b0, 1'b1);
    check("req_latency_t1", 64'(AERIN_REQ), 0);
    @(negedge clk);
    check("req_latency_t2", 64'(AERIN_REQ), 1);
    send(12'd17, 1'b0, 1'b1, 1'b0);
    send(12'd783, 1'b1, 1'b1, 1'b0);
    wait_results();
    fixed_good_en = 1'b0;

    // A done pulse while idle must not leak into the next sample
    stray_pulse = 1'b1;
    repeat (4) @(negedge clk);

    // Polarity latch: first event sets both, later events toggle them
    ack_min = 0; ack_max = 4;
    send(12'd100, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(AW'($urandom), i == 3, i[0], !i[0]);
    wait_results();

    // Randomized samples with starvation gaps
    for (int s = 0; s < 6; s++) begin
      len = $urandom_range(6, 1);
      p = 1'($urandom); t = 1'($urandom);
      for (int i = 0; i < len; i++) begin
        gap = $urandom_range(3, 0);
        repeat (gap) @(negedge clk);
        if (i == 0) send(AW'($urandom), i == len - 1, p, t);
        else        send(AW'($urandom), i == len - 1, 1'($urandom), 1'($urandom));
      end
    end
    wait_results();

    // Back-pressure: ACK stalled, push 20 back-to-back
    for (int i = 0; i < 20; i++) bp_addr[i] = AW'($urandom);
    ack_min = 0; ack_max = 1; ack_stall = 1'b1;
    sent = 0; blocked = 0;
    EVT_VALID = 1'b1;
    while (sent < 20 && blocked < 4) begin
      EVT_DATA = bp_addr[sent]; EVT_LAST = (sent == 19);
      SAMPLE_POS = 1'b1; SAMPLE_TRAIN = 1'b0;
      if (EVT_READY) begin
        record(bp_addr[sent], sent == 19, 1'b1, 1'b0);
        sent++;
      end else begin
        blocked++;
      end
      @(negedge clk);
    end
    check("bp_accepted", 64'(sent), 17);
    check("bp_ready_low", 64'(EVT_READY), 0);
    ack_stall = 1'b0;
    while (sent < 20) begin
      send(bp_addr[sent], sent == 19, 1'b0, 1'b1);
      sent++;
    end
    wait_results();

    // Early done during the final release phase
    early_done = 1'b1; ack_min = 1; ack_max = 2;
    send(AW'($urandom), 1'b0, 1'b0, 1'b0);
    send(AW'($urandom), 1'b1, 1'b0, 1'b0);
    wait_results();
    early_done = 1'b0;

    // Closure: a new event is refused until the result handshake completes
    ready_hold = 1'b1;
    send(12'd300, 1'b0, 1'b1, 1'b0);
    send(12'd301, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!RESULT_VALID && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("closure_result_valid", 64'(RESULT_VALID), 1);
    EVT_DATA = 12'd302; EVT_LAST = 1'b1; SAMPLE_POS = 1'b0; SAMPLE_TRAIN = 1'b1;
    EVT_VALID = 1'b1;
    refused = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (EVT_READY) refused = 1'b0;
      @(negedge clk);
    end
    check("closure_refused", 64'(refused), 1);
    ready_hold = 1'b0;
    n = 0;
    while (!EVT_READY && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("closure_accept_cycle", 64'(cyc + 1), 64'(hs_cycle + 1));
    if (EVT_READY) record(12'd302, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    EVT_VALID = 1'b0;
    wait_results();

    // Timeout: ACK never rises
    ack_never = 1'b1;
    send(12'h0AB, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (!AERIN_REQ && n < 10) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (AERIN_REQ && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    check("tmo_req_cycles", 64'(hi), 64'(TMO));
    check("tmo_flag", 64'(TIMEOUT_ERR), 1);
    check("tmo_evt_ready", 64'(EVT_READY), 0);
    check("tmo_req_low", 64'(AERIN_REQ), 0);
    RST = 1'b1;
    ack_never = 1'b0;
    exp_evt.delete(); exp_pol.delete(); exp_good.delete();
    in_sample = 1'b0;
    repeat (2) @(negedge clk);
    expected_results = results_done;
    RST = 1'b0;
    @(negedge clk);
    check_reset_state();

    // Normal operation resumes after reset
    ack_min = 0; ack_max = 2;
    send(12'd42, 1'b1, 1'b0, 1'b1);
    wait_results();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
